// File: rtl/axi_dma_write_mc_ctrl_if.sv
// AXI4 write-address/data/response channel bundle for the multi-channel write DMA.
interface axi_dma_write_mc_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axi_dma_write_mc_ctrl.sv
// Multi-channel AXI4 write DMA: round-robin job arbitration, 4 KB-safe INCR bursts,
// one outstanding burst at a time, per-channel completion/error pulses.
module axi_dma_write_mc_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 26,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           cmd_valid,
  output logic [NUM_CH-1:0]           cmd_ready,
  input  logic [NUM_CH*ADDR_W-1:0]    cmd_addr,
  input  logic [NUM_CH*LEN_W-1:0]     cmd_len,
  output logic [NUM_CH-1:0]           ch_idle,
  output logic [NUM_CH-1:0]           ch_irq,
  output logic [NUM_CH-1:0]           ch_err,
  output logic [$clog2(NUM_CH)-1:0]   src_ch,
  input  logic [DATA_W-1:0]           src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  axi_dma_write_mc_ctrl_if.master     axi
);
  localparam int unsigned BB     = DATA_W / 8;
  localparam int unsigned BB_LOG = $clog2(BB);
  localparam int unsigned REM_W  = LEN_W - BB_LOG;
  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned CW     = (REM_W > 13) ? REM_W : 13;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] busy_q, busy_d, pend_q, pend_d;
  logic [ADDR_W-1:0] addr_pend_q [NUM_CH];
  logic [ADDR_W-1:0] addr_pend_d [NUM_CH];
  logic [LEN_W-1:0]  len_pend_q [NUM_CH];
  logic [LEN_W-1:0]  len_pend_d [NUM_CH];
  logic [CH_W-1:0]   gnt_q, gnt_d, rr_q, rr_d, arb_gnt;
  logic              arb_found;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [8:0]        beats_q, beats_d, cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] ch_irq_q, ch_irq_d, ch_err_q, ch_err_d;
  logic              m_awvalid_q, m_awvalid_d, m_bready_q, m_bready_d;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [11:0] off, input logic [REM_W-1:0] rem);
    logic [CW-1:0] to4k;
    logic [CW-1:0] lim;
    to4k = CW'((13'h1000 - {1'b0, off}) >> BB_LOG);
    lim  = CW'(MAX_BURST);
    if (to4k < lim) lim = to4k;
    if (CW'(rem) < lim) lim = CW'(rem);
    return 9'(lim);
  endfunction

  // Round-robin search starting at rr_q (the channel after the last grant).
  always_comb begin
    arb_gnt   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (!arb_found && pend_q[(int'(rr_q) + k) % int'(NUM_CH)]) begin
        arb_found = 1'b1;
        arb_gnt   = CH_W'((int'(rr_q) + k) % int'(NUM_CH));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    pend_d      = pend_q;
    addr_pend_d = addr_pend_q;
    len_pend_d  = len_pend_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ch_irq_d    = '0;
    ch_err_d    = '0;

    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cmd_valid[i] && !busy_q[i]) begin
        busy_d[i]      = 1'b1;
        pend_d[i]      = 1'b1;
        addr_pend_d[i] = cmd_addr[i*ADDR_W +: ADDR_W];
        len_pend_d[i]  = cmd_len[i*LEN_W +: LEN_W];
      end
    end

    unique case (state_q)
      S_IDLE: if (arb_found) state_d = S_ARB;
      S_ARB: begin
        gnt_d           = arb_gnt;
        pend_d[arb_gnt] = 1'b0;
        rr_d            = (arb_gnt == CH_W'(NUM_CH - 1)) ? '0 : arb_gnt + 1'b1;
        addr_d          = addr_pend_q[arb_gnt];
        rem_d           = REM_W'(len_pend_q[arb_gnt] >> BB_LOG);
        err_d           = 1'b0;
        cnt_d           = '0;
        beats_d         = burst_beats(addr_d[11:0], rem_d);
        state_d         = (rem_d == '0) ? S_DONE : S_AW;
      end
      S_AW: if (axi.m_awready) state_d = S_W;
      S_W: begin
        if (src_valid && axi.m_wready) begin
          if (cnt_q == beats_q - 9'd1) state_d = S_B;
          else                         cnt_d   = cnt_q + 9'd1;
        end
      end
      S_B: begin
        if (axi.m_bvalid) begin
          addr_d  = addr_q + (ADDR_W'(beats_q) << BB_LOG);
          rem_d   = rem_q - REM_W'(beats_q);
          cnt_d   = '0;
          beats_d = burst_beats(addr_d[11:0], rem_d);
          if (axi.m_bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = (rem_d == '0) ? S_DONE : S_AW;
          end
        end
      end
      S_DONE: begin
        busy_d[gnt_q] = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      ch_irq_d[gnt_d] = 1'b1;
      ch_err_d[gnt_d] = err_d;
    end
    m_awvalid_d = (state_d == S_AW);
    m_bready_d  = (state_d == S_B);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      pend_q      <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        addr_pend_q[i] <= '0;
        len_pend_q[i]  <= '0;
      end
      gnt_q       <= '0;
      rr_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ch_irq_q    <= '0;
      ch_err_q    <= '0;
      m_awvalid_q <= 1'b0;
      m_bready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      addr_pend_q <= addr_pend_d;
      len_pend_q  <= len_pend_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ch_irq_q    <= ch_irq_d;
      ch_err_q    <= ch_err_d;
      m_awvalid_q <= m_awvalid_d;
      m_bready_q  <= m_bready_d;
    end
  end

  // The W channel is a straight pass-through of the source stream while in W.
  assign cmd_ready     = ~busy_q;
  assign ch_idle       = ~busy_q;
  assign ch_irq        = ch_irq_q;
  assign ch_err        = ch_err_q;
  assign src_ch        = gnt_q;
  assign src_ready     = (state_q == S_W) && axi.m_wready;
  assign axi.m_awaddr  = addr_q;
  assign axi.m_awlen   = 8'(beats_q - 9'd1);
  assign axi.m_awsize  = 3'(BB_LOG);
  assign axi.m_awburst = 2'b01;
  assign axi.m_awvalid = m_awvalid_q;
  assign axi.m_wdata   = src_data;
  assign axi.m_wstrb   = '1;
  assign axi.m_wlast   = (state_q == S_W) && (cnt_q == beats_q - 9'd1);
  assign axi.m_wvalid  = (state_q == S_W) && src_valid;
  assign axi.m_bready  = m_bready_q;
endmodule

// File: tb/tb_axi_dma_write_mc_ctrl.sv
// Directed bench for axi_dma_write_mc_ctrl: AXI slave and source stream driven step by step.
module tb_axi_dma_write_mc_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   cmd_valid, cmd_ready, ch_idle, ch_irq, ch_err;
  logic [127:0] cmd_addr;
  logic [103:0] cmd_len;
  logic [1:0]   src_ch;
  logic [63:0]  src_data;
  logic         src_valid, src_ready;
  int           n_assert = 0;
  int           n_fail   = 0;

  axi_dma_write_mc_ctrl_if #(.ADDR_W(32), .DATA_W(64)) axi ();

  axi_dma_write_mc_ctrl #(.NUM_CH(4), .ADDR_W(32), .DATA_W(64), .LEN_W(26), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ch_idle(ch_idle), .ch_irq(ch_irq),
    .ch_err(ch_err), .src_ch(src_ch), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .axi(axi)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end expected end of test");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int ch, input logic [31:0] addr, input logic [25:0] len);
    cmd_valid[ch]         = 1'b1;
    cmd_addr[ch*32 +: 32] = addr;
    cmd_len[ch*26 +: 26]  = len;
  endtask

  task automatic fire();
    logic [3:0] posted;
    posted = cmd_valid;
    tick();
    cmd_valid = '0;
    check("cmd_accept_idle", 64'(ch_idle & posted), 64'h0);
  endtask

  task automatic wait_aw(input string tag, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (!axi.m_awvalid && n < 64) begin tick(); n++; end
    check({tag, "_awvalid"}, 64'(axi.m_awvalid), 64'h1);
    check({tag, "_awaddr"},  64'(axi.m_awaddr),  64'(addr));
    check({tag, "_awlen"},   64'(axi.m_awlen),   64'(len));
    check({tag, "_awsize"},  64'(axi.m_awsize),  64'h3);
    check({tag, "_awburst"}, 64'(axi.m_awburst), 64'h1);
    axi.m_awready = 1'b1;
    tick();
    axi.m_awready = 1'b0;
    check({tag, "_awvalid_drop"}, 64'(axi.m_awvalid), 64'h0);
  endtask

  task automatic do_w(input string tag, input int ch, input int total, input int nsend);
    for (int b = 0; b < nsend; b++) begin
      src_valid    = 1'b1;
      src_data     = {32'(ch) + 32'hC0DE0000, 32'(b)};
      axi.m_wready = 1'b1;
      #1;
      check({tag, "_wvalid"},    64'(axi.m_wvalid), 64'h1);
      check({tag, "_wdata"},     axi.m_wdata,       {32'(ch) + 32'hC0DE0000, 32'(b)});
      check({tag, "_wstrb"},     64'(axi.m_wstrb),  64'hFF);
      check({tag, "_wlast"},     64'(axi.m_wlast),  64'(b == total - 1));
      check({tag, "_src_ready"}, 64'(src_ready),    64'h1);
      check({tag, "_src_ch"},    64'(src_ch),       64'(ch));
      tick();
    end
    if (nsend == total) begin
      src_valid    = 1'b0;
      axi.m_wready = 1'b0;
    end
  endtask

  task automatic do_b(input string tag, input logic [1:0] resp);
    int n = 0;
    while (!axi.m_bready && n < 32) begin tick(); n++; end
    check({tag, "_bready"}, 64'(axi.m_bready), 64'h1);
    axi.m_bvalid = 1'b1;
    axi.m_bresp  = resp;
    tick();
    axi.m_bvalid = 1'b0;
    axi.m_bresp  = 2'b00;
  endtask

  task automatic wait_irq(input string tag, input int ch, input logic err);
    int n = 0;
    while (ch_irq == 4'h0 && n < 32) begin tick(); n++; end
    check({tag, "_irq"},       64'(ch_irq),     64'(4'b1 << ch));
    check({tag, "_err"},       64'(ch_err),     64'({3'b0, err} << ch));
    check({tag, "_busy"},      64'(ch_idle[ch]), 64'h0);
    tick();
    check({tag, "_irq_pulse"}, 64'(ch_irq),     64'h0);
    check({tag, "_idle_back"}, 64'(ch_idle[ch]), 64'h1);
  endtask

  initial begin
    int   n;
    logic seen_aw;
    rst_n = 1'b0; cmd_valid = '0; cmd_addr = '0; cmd_len = '0;
    src_data = '0; src_valid = 1'b0;
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
    tick(); tick();
    check("rst_awvalid",   64'(axi.m_awvalid), 64'h0);
    check("rst_wvalid",    64'(axi.m_wvalid),  64'h0);
    check("rst_bready",    64'(axi.m_bready),  64'h0);
    check("rst_src_ready", 64'(src_ready),     64'h0);
    check("rst_cmd_ready", 64'(cmd_ready),     64'hF);
    check("rst_ch_idle",   64'(ch_idle),       64'hF);
    check("rst_src_ch",    64'(src_ch),        64'h0);
    check("rst_irq",       64'(ch_irq),        64'h0);
    rst_n = 1'b1;
    tick();

    // Four simultaneous jobs are served ch0..ch3 from the reset RR pointer.
    for (int c = 0; c < 4; c++) set_cmd(c, 32'h2000 + 32'(c) * 32'h1000, 26'h20);
    fire();
    for (int c = 0; c < 4; c++) begin
      wait_aw("t3", 32'h2000 + 32'(c) * 32'h1000, 8'd3);
      do_w("t3", c, 4, 4);
      do_b("t3", 2'b00);
      wait_irq("t3", c, 1'b0);
    end

    set_cmd(0, 32'h1000, 26'h40);
    fire();
    wait_aw("t1", 32'h1000, 8'd7);
    do_w("t1", 0, 8, 8);
    do_b("t1", 2'b00);
    wait_irq("t1", 0, 1'b0);

    set_cmd(1, 32'h0FC0, 26'h100);
    fire();
    wait_aw("t2a", 32'h0FC0, 8'd7);
    do_w("t2a", 1, 8, 8);
    do_b("t2a", 2'b00);
    wait_aw("t2b", 32'h1000, 8'd15);
    do_w("t2b", 1, 16, 16);
    do_b("t2b", 2'b00);
    wait_aw("t2c", 32'h1080, 8'd7);
    do_w("t2c", 1, 8, 8);
    do_b("t2c", 2'b00);
    wait_irq("t2", 1, 1'b0);

    // Last grant was ch1, so ch2 wins over ch0.
    set_cmd(0, 32'hA000, 26'h0);
    set_cmd(2, 32'hB000, 26'h0);
    fire();
    wait_irq("rr_first", 2, 1'b0);
    wait_irq("rr_second", 0, 1'b0);

    set_cmd(2, 32'h6000, 26'h100);
    fire();
    wait_aw("t4", 32'h6000, 8'd15);
    do_w("t4", 2, 16, 16);
    do_b("t4", 2'b10);
    check("t4_no_aw_at_done", 64'(axi.m_awvalid), 64'h0);
    wait_irq("t4", 2, 1'b1);
    check("t4_no_second_aw", 64'(axi.m_awvalid), 64'h0);

    set_cmd(3, 32'hC000, 26'h0);
    fire();
    n = 0; seen_aw = 1'b0;
    while (ch_irq == 4'h0 && n < 8) begin
      if (axi.m_awvalid) seen_aw = 1'b1;
      tick(); n++;
    end
    check("t5_len0_latency", 64'(n <= 3), 64'h1);
    check("t5_len0_no_aw",   64'(seen_aw), 64'h0);
    wait_irq("t5_len0", 3, 1'b0);

    set_cmd(0, 32'h7000, 26'h10);
    fire();
    n = 0;
    while (!axi.m_awvalid && n < 32) begin tick(); n++; end
    src_valid = 1'b1;
    src_data  = 64'hA5A5_5A5A_DEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_aw_hold",      64'(axi.m_awvalid), 64'h1);
      check("t5_aw_addr_hold", 64'(axi.m_awaddr),  64'h7000);
      check("t5_src_ready_aw", 64'(src_ready),     64'h0);
      tick();
    end
    wait_aw("t5", 32'h7000, 8'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_w_hold",      64'(axi.m_wvalid), 64'h1);
      check("t5_wdata_hold",  axi.m_wdata,       64'hA5A5_5A5A_DEAD_BEEF);
      check("t5_src_ready_w", 64'(src_ready),    64'h0);
      tick();
    end
    do_w("t5", 0, 2, 2);
    do_b("t5", 2'b00);
    wait_irq("t5", 0, 1'b0);

    set_cmd(1, 32'h8000, 26'h40);
    fire();
    wait_aw("t6", 32'h8000, 8'd7);
    do_w("t6", 1, 8, 3);
    rst_n = 1'b0;
    tick();
    check("t6_awvalid",   64'(axi.m_awvalid), 64'h0);
    check("t6_wvalid",    64'(axi.m_wvalid),  64'h0);
    check("t6_bready",    64'(axi.m_bready),  64'h0);
    check("t6_src_ready", 64'(src_ready),     64'h0);
    check("t6_ch_idle",   64'(ch_idle),       64'hF);
    check("t6_irq",       64'(ch_irq),        64'h0);
    rst_n = 1'b1; src_valid = 1'b0; axi.m_wready = 1'b0;
    tick();
    set_cmd(1, 32'h9000, 26'h20);
    fire();
    wait_aw("t6n", 32'h9000, 8'd3);
    do_w("t6n", 1, 4, 4);
    do_b("t6n", 2'b00);
    wait_irq("t6n", 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
